// File: rtl/sync_fifo.sv
// Single-clock FIFO over a register-file memory with registered read.
// Tracks occupancy and raises full/empty, almost flags and error pulses.
module sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH-2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // Flags decode only the registered count; no input-to-flag path.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A read at full frees a slot, so the paired write is accepted.
    assign rd_acc = ren & ~empty;
    assign wr_acc = wen & (~full | ren);

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Read-before-write at full: the old word is sampled before update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata <= mem[rptr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + ONE_C;
        end else if (rd_acc && !wr_acc) begin
            count <= count - ONE_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wen & ~wr_acc;
            underflow <= ren & empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference.
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       wen;
    logic [7:0] wdata;
    logic       ren;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int total;
    int bad;

    logic [7:0] q[$];
    logic [7:0] m_rdata;
    logic       m_rvalid;
    logic       m_ovf;
    logic       m_unf;

    sync_fifo dut (
        .clk(clk),
        .rst(rst),
        .wen(wen),
        .wdata(wdata),
        .ren(ren),
        .rdata(rdata),
        .rvalid(rvalid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == 16));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("afull", 32'(almost_full), 32'(n >= 14));
        chk("aempty", 32'(almost_empty), 32'(n <= 2));
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("rdata", 32'(rdata), 32'(m_rdata));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        chk("unf", 32'(underflow), 32'(m_unf));
    endtask

    // Reference: accept rules applied to a plain queue.
    task automatic model(input logic w, input logic r, input logic [7:0] d);
        bit was_empty;
        bit was_full;
        bit rd;
        bit wr;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == 16);
        rd = r && !was_empty;
        wr = w && (!was_full || r);
        m_rvalid = rd;
        if (rd) m_rdata = q.pop_front();
        if (wr) q.push_back(d);
        m_ovf = w && !wr;
        m_unf = r && was_empty;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wen   = w;
        ren   = r;
        wdata = d;
        @(posedge clk);
        model(w, r, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        q.delete();
        m_rdata  = 8'h00;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = 8'h00;
        m_rdata  = 8'h00;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 8'hEE);
        chk("fill_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ovf_pulse", 32'(overflow), 32'd0);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_data", 32'(rdata), 32'(i));
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("drain_unf", 32'(underflow), 32'd1);
        chk("drain_hold", 32'(rdata), 32'h0F);

        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(i + 8'h10));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("wrap_data", 32'(rdata), 32'(8'hA0 + i));
        end
        chk("wrap_cnt", 32'(count), 32'd0);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        cyc(1'b1, 1'b1, 8'h55);
        chk("full_rw_cnt", 32'(count), 32'd16);
        chk("full_rw_old", 32'(rdata), 32'hC0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("full_rw_last", 32'(rdata), 32'h55);

        cyc(1'b1, 1'b1, 8'h33);
        chk("empty_rw_unf", 32'(underflow), 32'd1);
        chk("empty_rw_cnt", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("empty_rw_data", 32'(rdata), 32'h33);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
        cyc(1'b0, 1'b1, 8'h00);
        wen = 1'b0;
        ren = 1'b0;
        do_reset();
        cyc(1'b1, 1'b0, 8'h77);
        cyc(1'b0, 1'b1, 8'h00);
        chk("rst_rd", 32'(rdata), 32'h77);

        for (int i = 0; i < 3000; i++) begin
            int wp;
            int rp;
            wp = (i / 500) % 2 == 0 ? 70 : 35;
            rp = 100 - wp;
            cyc(($urandom % 100) < wp, ($urandom % 100) < rp,
                8'($urandom));
        end
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, 1'b1, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
